// File: rtl/sfa_pkg.sv
// Shared fabric definitions: default data width and occupancy-counter sizing.
// Latency: none (types and constants only).
// Backpressure: not applicable.
package sfa_pkg;

    localparam int SFA_DW = 32;

    // Occupancy counter must represent 0..depth inclusive.
    function automatic int count_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/sfa_in_buffer_if.sv
// Valid/ready word stream between input switch, buffer and PE.
// Latency: none (wires only).
// Backpressure: tready from the sink throttles tvalid/tdata from the source.
interface sfa_in_buffer_if
    import sfa_pkg::*;
#(
    parameter int DW = SFA_DW
);
    logic          tvalid;
    logic          tready;
    logic [DW-1:0] tdata;

    modport master (output tvalid, output tdata, input tready);
    modport slave  (input tvalid, input tdata, output tready);
endinterface

// File: rtl/sfa_buf_ram.sv
// DEPTH x DW storage, one synchronous write port, one asynchronous read port.
// Latency: write visible on read port the cycle after the write edge.
// Backpressure: none; the controller owns all flow control. Contents are not reset.
module sfa_buf_ram #(
    parameter int DEPTH = 4,
    parameter int DW    = 32
) (
    input  logic                     ACLK,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [DW-1:0]            wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [DW-1:0]            rdata
);
    logic [DW-1:0] mem [DEPTH];

    // Write the tail word; never reset, stale entries are hidden by the empty flag.
    always_ff @(posedge ACLK) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];
endmodule

// File: rtl/sfa_in_buffer.sv
// First-word-fall-through input buffer between an input switch and a PE.
// Latency: one cycle from push edge to mo valid; no combinational si->mo path.
// Backpressure: si.tready drops only when full (never follows mo.tready); FLUSH consumes and drops.
module sfa_in_buffer
    import sfa_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int DW    = SFA_DW
) (
    input  logic                        ACLK,
    input  logic                        ARESET,
    input  logic                        FLUSH,
    sfa_in_buffer_if.slave              si,
    sfa_in_buffer_if.master             mo,
    output logic [count_w(DEPTH)-1:0]   COUNT
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = count_w(DEPTH);
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          in_rdy;
    logic          out_vld;
    logic          push;
    logic          pop;
    logic [DW-1:0] head;

    // Ready is a function of occupancy only, so a full buffer never passes a word through.
    assign in_rdy  = !ARESET && (count != FULL);
    assign out_vld = !ARESET && (count != '0);
    assign push    = si.tvalid && in_rdy;
    assign pop     = out_vld && mo.tready;

    assign si.tready = in_rdy;
    assign mo.tvalid = out_vld;
    assign mo.tdata  = out_vld ? head : '0;
    assign COUNT     = count;

    // Pointers wrap naturally at AW bits; reset beats flush, flush beats any handshake.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (FLUSH) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    sfa_buf_ram #(
        .DEPTH (DEPTH),
        .DW    (DW)
    ) u_ram (
        .ACLK  (ACLK),
        .we    (push && !FLUSH),
        .waddr (wr_ptr),
        .wdata (si.tdata),
        .raddr (rd_ptr),
        .rdata (head)
    );
endmodule

// File: tb/tb_sfa_in_buffer.sv
module tb_sfa_in_buffer;
    localparam int DEPTH = 4;
    localparam int DW    = 32;

    logic       ACLK   = 1'b0;
    logic       ARESET = 1'b1;
    logic       FLUSH  = 1'b0;
    logic [2:0] COUNT;

    always #5 ACLK = ~ACLK;

    sfa_in_buffer_if #(.DW(DW)) si_bus ();
    sfa_in_buffer_if #(.DW(DW)) mo_bus ();

    sfa_in_buffer #(.DEPTH(DEPTH), .DW(DW)) dut (
        .ACLK   (ACLK),
        .ARESET (ARESET),
        .FLUSH  (FLUSH),
        .si     (si_bus),
        .mo     (mo_bus),
        .COUNT  (COUNT)
    );

    typedef struct packed {
        logic        rdy;
        logic        vld;
        logic [31:0] dat;
        logic [2:0]  cnt;
    } obs_t;

    logic [31:0] model_q[$];
    logic [31:0] pushed[$];
    logic [31:0] popped[$];
    int n_cmp = 0;
    int n_err = 0;

    // One clock of stimulus: observe DUT at negedge, predict from the scoreboard, advance the model.
    task automatic step(input logic v, input logic [31:0] d, input logic r, input logic fl,
                        output obs_t o, output obs_t e);
        si_bus.tvalid = v;
        si_bus.tdata  = d;
        mo_bus.tready = r;
        FLUSH         = fl;
        @(negedge ACLK);
        o.rdy = si_bus.tready;
        o.vld = mo_bus.tvalid;
        o.dat = mo_bus.tdata;
        o.cnt = COUNT;
        e.rdy = !ARESET && (model_q.size() != DEPTH);
        e.vld = !ARESET && (model_q.size() != 0);
        e.dat = e.vld ? model_q[0] : 32'h0;
        e.cnt = 3'(model_q.size());
        if (ARESET || fl) begin
            model_q.delete();
        end else begin
            if (e.vld && r) popped.push_back(model_q.pop_front());
            if (v && e.rdy) begin
                model_q.push_back(d);
                pushed.push_back(d);
            end
        end
        @(posedge ACLK);
        #1;
    endtask

    task automatic test_reset();
        obs_t o, e;
        for (int i = 0; i < 2; i++) begin
            step(1'b1, 32'h11, 1'b1, 1'b0, o, e);
            n_cmp++;
            if (o !== e) begin
                n_err++;
                $display("FAIL reset_hold: got rdy=%b vld=%b dat=%h cnt=%0d want rdy=%b vld=%b dat=%h cnt=%0d",
                         o.rdy, o.vld, o.dat, o.cnt, e.rdy, e.vld, e.dat, e.cnt);
            end
            n_cmp++;
            if (o.cnt !== 3'd0) begin
                n_err++;
                $display("FAIL reset_count: got %0d want 0", o.cnt);
            end
        end
        ARESET = 1'b0;
        step(1'b0, 32'h0, 1'b0, 1'b0, o, e);
        n_cmp++;
        if (o.rdy !== 1'b1 || o.vld !== 1'b0 || o.dat !== 32'h0) begin
            n_err++;
            $display("FAIL reset_release: got rdy=%b vld=%b dat=%h want rdy=1 vld=0 dat=0", o.rdy, o.vld, o.dat);
        end
    endtask

    task automatic test_single_push();
        obs_t o, e;
        logic        tv[4] = '{1'b1, 1'b0, 1'b0, 1'b0};
        logic        tr[4] = '{1'b0, 1'b0, 1'b1, 1'b0};
        logic [31:0] td[4] = '{32'hA5A5_0001, 32'h0, 32'h0, 32'h0};
        for (int i = 0; i < 4; i++) begin
            step(tv[i], td[i], tr[i], 1'b0, o, e);
            n_cmp++;
            if (o !== e) begin
                n_err++;
                $display("FAIL single_push[%0d]: got rdy=%b vld=%b dat=%h cnt=%0d want rdy=%b vld=%b dat=%h cnt=%0d",
                         i, o.rdy, o.vld, o.dat, o.cnt, e.rdy, e.vld, e.dat, e.cnt);
            end
            if (i == 1) begin
                n_cmp++;
                if (o.vld !== 1'b1 || o.dat !== 32'hA5A5_0001 || o.cnt !== 3'd1) begin
                    n_err++;
                    $display("FAIL single_push_fwft: got vld=%b dat=%h cnt=%0d want vld=1 dat=a5a50001 cnt=1",
                             o.vld, o.dat, o.cnt);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        obs_t o, e;
        logic [31:0] exp5[5] = '{32'h1, 32'h2, 32'h3, 32'h4, 32'h5};
        logic v5;
        pushed.delete();
        popped.delete();
        for (int i = 1; i <= 4; i++) begin
            step(1'b1, 32'(i), 1'b0, 1'b0, o, e);
            n_cmp++;
            if (o !== e) begin
                n_err++;
                $display("FAIL b2b_fill[%0d]: got rdy=%b vld=%b dat=%h cnt=%0d want rdy=%b vld=%b dat=%h cnt=%0d",
                         i, o.rdy, o.vld, o.dat, o.cnt, e.rdy, e.vld, e.dat, e.cnt);
            end
        end
        step(1'b1, 32'h5, 1'b0, 1'b0, o, e);
        n_cmp++;
        if (o.cnt !== 3'd4 || o.rdy !== 1'b0) begin
            n_err++;
            $display("FAIL b2b_full: got cnt=%0d rdy=%b want cnt=4 rdy=0", o.cnt, o.rdy);
        end
        v5 = 1'b1;
        for (int c = 0; c < 20 && (popped.size() < 5 || model_q.size() != 0); c++) begin
            step(v5, 32'h5, 1'b1, 1'b0, o, e);
            if (v5 && e.rdy) v5 = 1'b0;
            n_cmp++;
            if (o !== e) begin
                n_err++;
                $display("FAIL b2b_drain[%0d]: got rdy=%b vld=%b dat=%h cnt=%0d want rdy=%b vld=%b dat=%h cnt=%0d",
                         c, o.rdy, o.vld, o.dat, o.cnt, e.rdy, e.vld, e.dat, e.cnt);
            end
        end
        n_cmp++;
        if (popped.size() != 5) begin
            n_err++;
            $display("FAIL b2b_count: got %0d words want 5", popped.size());
        end else begin
            for (int i = 0; i < 5; i++) begin
                n_cmp++;
                if (popped[i] !== exp5[i]) begin
                    n_err++;
                    $display("FAIL b2b_order[%0d]: got %h want %h", i, popped[i], exp5[i]);
                end
            end
        end
    endtask

    task automatic test_full_simul();
        obs_t o, e;
        logic [31:0] nd;
        pushed.delete();
        popped.delete();
        for (int i = 0; i < 4; i++) step(1'b1, 32'h100 + 32'(i), 1'b0, 1'b0, o, e);
        nd = 32'h200;
        for (int c = 0; c < 8; c++) begin
            step(1'b1, nd, 1'b1, 1'b0, o, e);
            if (e.rdy) nd = nd + 32'h1;
            n_cmp++;
            if (o !== e) begin
                n_err++;
                $display("FAIL simul[%0d]: got rdy=%b vld=%b dat=%h cnt=%0d want rdy=%b vld=%b dat=%h cnt=%0d",
                         c, o.rdy, o.vld, o.dat, o.cnt, e.rdy, e.vld, e.dat, e.cnt);
            end
            n_cmp++;
            if (c == 0 && (o.rdy !== 1'b0 || o.cnt !== 3'd4)) begin
                n_err++;
                $display("FAIL simul_first: got rdy=%b cnt=%0d want rdy=0 cnt=4", o.rdy, o.cnt);
            end else if (c > 0 && (o.rdy !== 1'b1 || o.cnt !== 3'd3)) begin
                n_err++;
                $display("FAIL simul_steady[%0d]: got rdy=%b cnt=%0d want rdy=1 cnt=3", c, o.rdy, o.cnt);
            end
        end
        for (int c = 0; c < 10 && model_q.size() != 0; c++) step(1'b0, 32'h0, 1'b1, 1'b0, o, e);
        n_cmp++;
        if (popped.size() != pushed.size() || o.cnt !== 3'd1) begin
            n_err++;
            $display("FAIL simul_drain: got %0d words (cnt before last pop %0d) want %0d", popped.size(), o.cnt, pushed.size());
        end else begin
            for (int i = 0; i < popped.size(); i++) begin
                n_cmp++;
                if (popped[i] !== pushed[i]) begin
                    n_err++;
                    $display("FAIL simul_order[%0d]: got %h want %h", i, popped[i], pushed[i]);
                end
            end
        end
    endtask

    task automatic test_stream();
        obs_t o, e;
        pushed.delete();
        popped.delete();
        for (int i = 0; i < 21; i++) begin
            step(i < 20, 32'h2000 + 32'(i), 1'b1, 1'b0, o, e);
            n_cmp++;
            if (o !== e || o.cnt > 3'd1) begin
                n_err++;
                $display("FAIL stream[%0d]: got rdy=%b vld=%b dat=%h cnt=%0d want rdy=%b vld=%b dat=%h cnt=%0d",
                         i, o.rdy, o.vld, o.dat, o.cnt, e.rdy, e.vld, e.dat, e.cnt);
            end
        end
        n_cmp++;
        if (popped.size() != 20) begin
            n_err++;
            $display("FAIL stream_count: got %0d words want 20", popped.size());
        end else begin
            for (int i = 0; i < 20; i++) begin
                n_cmp++;
                if (popped[i] !== 32'h2000 + 32'(i)) begin
                    n_err++;
                    $display("FAIL stream_order[%0d]: got %h want %h", i, popped[i], 32'h2000 + 32'(i));
                end
            end
        end
    endtask

    task automatic test_flush();
        obs_t o, e;
        for (int i = 0; i < 3; i++) step(1'b1, 32'h400 + 32'(i), 1'b0, 1'b0, o, e);
        step(1'b1, 32'hDEAD, 1'b0, 1'b1, o, e);
        n_cmp++;
        if (o.rdy !== 1'b1 || o.cnt !== 3'd3) begin
            n_err++;
            $display("FAIL flush_cycle: got rdy=%b cnt=%0d want rdy=1 cnt=3", o.rdy, o.cnt);
        end
        for (int c = 0; c < 4; c++) begin
            step(1'b0, 32'h0, 1'b1, 1'b0, o, e);
            n_cmp++;
            if (o !== e || o.cnt !== 3'd0 || o.vld !== 1'b0 || o.dat === 32'hDEAD) begin
                n_err++;
                $display("FAIL flush_after[%0d]: got vld=%b dat=%h cnt=%0d want vld=0 dat=0 cnt=0",
                         c, o.vld, o.dat, o.cnt);
            end
        end
    endtask

    task automatic test_areset_mid();
        obs_t o, e;
        step(1'b1, 32'h300, 1'b0, 1'b0, o, e);
        step(1'b1, 32'h301, 1'b0, 1'b0, o, e);
        ARESET = 1'b1;
        step(1'b1, 32'hBEEF, 1'b1, 1'b0, o, e);
        ARESET = 1'b0;
        n_cmp++;
        if (o.rdy !== 1'b0 || o.vld !== 1'b0 || o.dat !== 32'h0) begin
            n_err++;
            $display("FAIL areset_during: got rdy=%b vld=%b dat=%h want rdy=0 vld=0 dat=0", o.rdy, o.vld, o.dat);
        end
        step(1'b1, 32'h77, 1'b0, 1'b0, o, e);
        n_cmp++;
        if (o.cnt !== 3'd0 || o.vld !== 1'b0 || o.rdy !== 1'b1) begin
            n_err++;
            $display("FAIL areset_release: got cnt=%0d vld=%b rdy=%b want cnt=0 vld=0 rdy=1", o.cnt, o.vld, o.rdy);
        end
        step(1'b0, 32'h0, 1'b1, 1'b0, o, e);
        n_cmp++;
        if (o.vld !== 1'b1 || o.dat !== 32'h77 || o.cnt !== 3'd1) begin
            n_err++;
            $display("FAIL areset_push: got vld=%b dat=%h cnt=%0d want vld=1 dat=77 cnt=1", o.vld, o.dat, o.cnt);
        end
        step(1'b0, 32'h0, 1'b0, 1'b0, o, e);
        n_cmp++;
        if (o !== e || o.vld !== 1'b0) begin
            n_err++;
            $display("FAIL areset_empty: got vld=%b dat=%h cnt=%0d want vld=0 dat=0 cnt=0", o.vld, o.dat, o.cnt);
        end
    endtask

    initial begin
        si_bus.tvalid = 1'b0;
        si_bus.tdata  = '0;
        mo_bus.tready = 1'b0;
        repeat (2) @(posedge ACLK);
        #1;
        test_reset();
        test_single_push();
        test_back_to_back();
        test_full_simul();
        test_stream();
        test_flush();
        test_areset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation still running at 200000, want finished");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/sfa_in_buffer.md
SFA_IN_BUFFER -- requirements
Module: sfa_in_buffer

Interface
REQ-001 Parameter DEPTH, default 4, buffer depth in words; SHALL be a power of two >= 2.
REQ-002 Parameter DW, default 32, data width in bits.
REQ-003 ACLK  input  1  sole clock; all state changes on rising edge.
REQ-004 ARESET  input  1  reset, synchronous, active-high.
REQ-005 FLUSH  input  1  synchronous buffer clear, asserted on input-switch reconfiguration.
REQ-006 si_tready  output  1  upstream ready (to input switch mi_tready).
REQ-007 si_tvalid  input  1  upstream valid (from input switch mi_tvalid).
REQ-008 si_tdata  input  DW  upstream data (from input switch mi_tdata).
REQ-009 mo_tready  input  1  downstream (PE) ready.
REQ-010 mo_tvalid  output  1  downstream valid.
REQ-011 mo_tdata  output  DW  downstream data.
REQ-012 COUNT  output  log2(DEPTH)+1  current occupancy, 0..DEPTH.

Function
REQ-013 Push SHALL occur on a cycle with si_tvalid && si_tready; pop on a cycle with mo_tvalid && mo_tready.
REQ-014 Buffer SHALL be first-word-fall-through: a word pushed at edge N SHALL appear on mo_tdata with mo_tvalid=1 after edge N, i.e. one-cycle latency, no combinational si->mo path.
REQ-015 si_tready SHALL equal !ARESET && (COUNT != DEPTH); it SHALL NOT depend on mo_tready (no pass-through when full).
REQ-016 mo_tvalid SHALL equal (COUNT != 0); mo_tdata SHALL be the head word when mo_tvalid=1, else all zeros.
REQ-017 Push only: COUNT+1; pop only: COUNT-1; simultaneous push and pop: COUNT unchanged, head advances, new word written at tail.
REQ-018 Write and read pointers SHALL be log2(DEPTH) bits and wrap modulo DEPTH without extra logic.
REQ-019 Data SHALL leave in exact arrival order; no word duplicated or dropped except by FLUSH/ARESET.
REQ-020 mo_tdata/mo_tvalid SHALL hold stable while mo_tvalid=1 && mo_tready=0.
REQ-021 FLUSH=1 SHALL set both pointers and COUNT to 0 at the next edge; a push or pop coincident with FLUSH SHALL be discarded; si_tready SHALL stay asserted during FLUSH (upstream word is consumed and dropped).
REQ-022 mo_tready asserted while empty SHALL have no effect.

Reset
REQ-023 ARESET=1 SHALL, at the next edge, clear pointers and COUNT to 0; while asserted, si_tready=0, mo_tvalid=0, mo_tdata=0.
REQ-024 ARESET SHALL take priority over FLUSH and any handshake; reset mid-stream discards all stored words.
REQ-025 Storage array SHALL NOT be reset; its contents are never visible while COUNT=0.

Structure
REQ-026 DW default and the COUNT-width function SHALL live in shared package sfa_pkg, used by the whole fabric.
REQ-027 Storage SHALL be one sub-module sfa_buf_ram (DEPTH x DW, one write port, one asynchronous read port); pointer/count control stays in sfa_in_buffer.
REQ-028 sfa_in_buffer SHALL be instantiated directly downstream of each input switch, mi_* to si_*.

Verification
REQ-029 Reset then single push 0xA5A5_0001 with mo_tready=0 -> next cycle mo_tvalid=1, mo_tdata=0xA5A5_0001, COUNT=1.
REQ-030 Push 0x1,0x2,0x3,0x4 back-to-back, mo_tready=0 (DEPTH=4) -> COUNT=4, si_tready=0; fifth word held upstream, not lost; then mo_tready=1 -> 0x1..0x4 then 0x5 in order.
REQ-031 Full buffer, si_tvalid=1 and mo_tready=1 together -> first cycle pop only (si_tready=0), then sustained one push + one pop per cycle, COUNT steady at 3.
REQ-032 Stream 20 words continuously with mo_tready=1 -> pointers wrap 5 times, output sequence identical to input, COUNT toggles 0/1 only.
REQ-033 COUNT=3, FLUSH=1 with si_tvalid=1 (0xDEAD) -> next cycle COUNT=0, mo_tvalid=0, 0xDEAD never appears on mo_tdata.
REQ-034 COUNT=2, ARESET=1 for 1 cycle mid-stream -> si_tready=0 during reset, COUNT=0, mo_tvalid=0, mo_tdata=0; normal push accepted the cycle after release.
